// File: rtl/alu_pkg.sv
// Shared ALU control encodings, opcode classes and sequencer state type
// used by the ALU op sequencer and its decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SLR = 3'b111;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_VRTYPE   = 6'b100000;
  localparam logic [3:0] OP_IMM_PFX  = 4'b0010;
  // Branch class is 00x100: compare under a mask that ignores bit 3
  localparam logic [5:0] OP_BRANCH      = 6'b000100;
  localparam logic [5:0] OP_BRANCH_MASK = 6'b110111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MWAIT
  } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {Opcode, Func, ALUOp} into ALU control code,
// vector/mul class flags and an illegal-function flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [2:0] func,
  input  logic       aluop,
  output logic [2:0] ctrl,
  output logic       is_vector,
  output logic       is_mul,
  output logic       illegal
);

  always_comb begin
    ctrl      = ALU_ADD;
    is_vector = 1'b0;
    illegal   = 1'b0;
    if (aluop) begin
      if (opcode == OP_RTYPE) begin
        case (func)
          ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLL, ALU_SLR, ALU_XOR: ctrl = func;
          default: illegal = 1'b1;
        endcase
      end else if (opcode == OP_VRTYPE) begin
        case (func)
          ALU_ADD, ALU_SUB, ALU_MUL, ALU_XOR: begin
            ctrl      = func;
            is_vector = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end else if (opcode[5:2] == OP_IMM_PFX) begin
        case (opcode[1:0])
          2'b00:   ctrl = ALU_ADD;
          2'b01:   ctrl = ALU_SUB;
          2'b10:   ctrl = ALU_MUL;
          default: illegal = 1'b1;
        endcase
      end else if ((opcode & OP_BRANCH_MASK) == OP_BRANCH) begin
        ctrl = ALU_SUB;
      end
    end
    is_mul = (ctrl == ALU_MUL);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer: accepts one decoded instruction per
// handshake and issues it as one scalar beat or GROUPS vector lane-group beats.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int unsigned VLEN      = 16,
  parameter  int unsigned ALU_LANES = 4,
  parameter  int unsigned MUL_LAT   = 2,
  localparam int unsigned GROUPS    = VLEN / ALU_LANES,
  localparam int unsigned GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           Opcode,
  input  logic [2:0]           Func,
  input  logic                 ALUOp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           ALUControl,
  output logic [GW-1:0]        LaneGroup,
  output logic [ALU_LANES-1:0] LaneMask,
  output logic                 LastBeat,
  output logic                 IllegalOp
);

  localparam logic [GW-1:0] LAST_GRP  = GW'(GROUPS - 1);
  localparam bit            MUL_STALL = (MUL_LAT > 1);
  localparam logic [2:0]    WAIT_LAST = MUL_STALL ? 3'(MUL_LAT - 2) : 3'd0;

  seq_state_t    state_q, state_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          vec_q, vec_d;
  logic          mul_q, mul_d;
  logic          ill_q, ill_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [2:0]    wcnt_q, wcnt_d;

  logic [2:0] dec_ctrl;
  logic       dec_vec, dec_mul, dec_ill;
  logic       last, accept;

  alu_op_decode u_decode (
    .opcode    (Opcode),
    .func      (Func),
    .aluop     (ALUOp),
    .ctrl      (dec_ctrl),
    .is_vector (dec_vec),
    .is_mul    (dec_mul),
    .illegal   (dec_ill)
  );

  assign last     = (state_q == ISSUE) && (!vec_q || (grp_q == LAST_GRP));
  assign in_ready = rst && ((state_q == IDLE) || ((state_q == ISSUE) && out_ready && last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    vec_d   = vec_q;
    mul_d   = mul_q;
    ill_d   = ill_q;
    grp_d   = grp_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: ;
      ISSUE: begin
        if (out_ready) begin
          if (last) begin
            state_d = IDLE;
            ctrl_d  = ALU_ADD;
            vec_d   = 1'b0;
            mul_d   = 1'b0;
            ill_d   = 1'b0;
            grp_d   = '0;
          end else if (mul_q && MUL_STALL) begin
            state_d = MWAIT;
            wcnt_d  = '0;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      MWAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d = ISSUE;
          grp_d   = grp_q + 1'b1;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Acceptance only happens in IDLE or on a completing last beat, so it
    // overrides the IDLE return above to give back-to-back issue.
    if (accept) begin
      state_d = ISSUE;
      ctrl_d  = dec_ctrl;
      vec_d   = dec_vec;
      mul_d   = dec_mul;
      ill_d   = dec_ill;
      grp_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctrl_q  <= ALU_ADD;
      vec_q   <= 1'b0;
      mul_q   <= 1'b0;
      ill_q   <= 1'b0;
      grp_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      vec_q   <= vec_d;
      mul_q   <= mul_d;
      ill_q   <= ill_d;
      grp_q   <= grp_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign out_valid  = (state_q == ISSUE);
  assign ALUControl = ctrl_q;
  assign LaneGroup  = grp_q;
  assign LaneMask   = (state_q == IDLE) ? '0 : (vec_q ? '1 : ALU_LANES'(1));
  assign LastBeat   = last;
  assign IllegalOp  = (state_q == ISSUE) && ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer (VLEN=16, 4 lanes, MUL_LAT=3).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] Opcode;
  logic [2:0] Func;
  logic       ALUOp;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] ALUControl;
  logic [1:0] LaneGroup;
  logic [3:0] LaneMask;
  logic       LastBeat;
  logic       IllegalOp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_op_sequencer #(.VLEN(16), .ALU_LANES(4), .MUL_LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Opcode     (Opcode),
    .Func       (Func),
    .ALUOp      (ALUOp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUControl (ALUControl),
    .LaneGroup  (LaneGroup),
    .LaneMask   (LaneMask),
    .LastBeat   (LastBeat),
    .IllegalOp  (IllegalOp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] fn, input logic aop);
    Opcode   = op;
    Func     = fn;
    ALUOp    = aop;
    in_valid = 1'b1;
    check("issue_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [2:0] ctrl, input logic [1:0] grp,
                      input logic [3:0] mask, input logic lastb, input logic ill);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_ctrl"}, ALUControl, ctrl);
    check({tag, "_grp"}, LaneGroup, grp);
    check({tag, "_mask"}, LaneMask, mask);
    check({tag, "_last"}, LastBeat, lastb);
    check({tag, "_ill"}, IllegalOp, ill);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Opcode    = '0;
    Func      = '0;
    ALUOp     = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      Opcode    = 6'($urandom);
      Func      = 3'($urandom);
      ALUOp     = 1'($urandom);
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_ctrl", ALUControl, 0);
      check("rst_ready", in_ready, 0);
      check("rst_mask", LaneMask, 0);
      check("rst_last", LastBeat, 0);
      check("rst_ill", IllegalOp, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("rel_ready", in_ready, 1);
    tick();
    check("idle_valid", out_valid, 0);

    // Scalar add
    issue(6'b000000, 3'b000, 1'b1);
    beat("sadd", 3'b000, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    check("sadd_done", out_valid, 0);

    // Vector xor, second op chained on the last beat
    issue(6'b100000, 3'b101, 1'b1);
    for (int g = 0; g < 4; g++) begin
      beat("vxor", 3'b101, 2'(g), 4'b1111, (g == 3), 1'b0);
      check("vxor_ready", in_ready, (g == 3));
      if (g == 3) begin
        Opcode   = 6'b000000;
        Func     = 3'b001;
        ALUOp    = 1'b1;
        in_valid = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    beat("chain", 3'b001, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    check("chain_done", out_valid, 0);

    // Vector mul with MUL_LAT=3: beats every 3rd cycle over 10 cycles
    issue(6'b100000, 3'b010, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("vmul_valid", out_valid, (c % 3 == 0));
      if (c % 3 == 0) begin
        check("vmul_ctrl", ALUControl, 3'b010);
        check("vmul_grp", LaneGroup, c / 3);
        check("vmul_last", LastBeat, (c == 9));
      end
      tick();
    end
    check("vmul_done", out_valid, 0);

    // Backpressure at group 1 of vector sub
    issue(6'b100000, 3'b001, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat("bp", 3'b001, 2'd1, 4'b1111, 1'b0, 1'b0);
      check("bp_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    check("bp_hold_grp", LaneGroup, 1);
    tick();
    check("bp_grp2", LaneGroup, 2);
    tick();
    beat("bp_g3", 3'b001, 2'd3, 4'b1111, 1'b1, 1'b0);
    tick();
    check("bp_done", out_valid, 0);

    // Illegal vector func: single beat
    issue(6'b100000, 3'b011, 1'b1);
    beat("vill", 3'b000, 2'd0, 4'b0001, 1'b1, 1'b1);
    tick();
    check("vill_nosticky", IllegalOp, 0);
    check("vill_done", out_valid, 0);

    issue(6'b001011, 3'b000, 1'b1);
    beat("imm11", 3'b000, 2'd0, 4'b0001, 1'b1, 1'b1);
    tick();
    issue(6'b001001, 3'b000, 1'b1);
    beat("imm01", 3'b001, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    issue(6'b000100, 3'b000, 1'b1);
    beat("beq", 3'b001, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    issue(6'b001100, 3'b110, 1'b1);
    beat("bxx", 3'b001, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    issue(6'b000000, 3'b111, 1'b1);
    beat("slr", 3'b111, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    issue(6'b000000, 3'b100, 1'b1);
    beat("rill", 3'b000, 2'd0, 4'b0001, 1'b1, 1'b1);
    tick();
    issue(6'b100000, 3'b010, 1'b0);
    beat("aluop0", 3'b000, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();
    issue(6'b111111, 3'b101, 1'b1);
    beat("other", 3'b000, 2'd0, 4'b0001, 1'b1, 1'b0);
    tick();

    // Reset mid-vector at group 2
    issue(6'b100000, 3'b000, 1'b1);
    tick();
    tick();
    check("mid_grp", LaneGroup, 2);
    rst = 1'b0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_grp0", LaneGroup, 0);
    check("mid_mask", LaneMask, 0);
    check("mid_ready", in_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
